// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// UART transmit framer. A word presented on txdata is latched when load is
// seen in IDLE, and is sent on tx as one start bit, DATA_W data bits (LSB
// first), an optional parity bit and STOP_BITS stop bits. Each bit lasts from
// one baud_tick to the next.
//
// Build option:
//   UART_TX_PARITY_EN  defined   : parity register, PARITY state and
//                                  parity_mode decode are built.
//                      undefined : parity_mode is ignored, parity reads 0 and
//                                  frames never carry a parity bit.
//
// Parameters:
//   DATA_W     data bits per frame (4..9)
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   baud_tick    in   one-cycle bit-boundary strobe from the baud generator
//   load         in   frame request, only looked at while idle
//   txdata       in   word to send, captured on the accepting edge
//   parity_mode  in   00 none, 01 even, 10 odd, 11 none
//   tx           out  serial line, idles high
//   busy         out  frame in progress
//   done         out  one-cycle pulse as the last stop bit ends
//   parity       out  parity of the most recently accepted word
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, waiting for load
// ARM    | word latched, line high, waiting for the first tick
// START  | start bit (line low)
// DATA   | data bits, LSB first, from the shift register
// PARITY | parity bit (only reachable with parity compiled in)
// STOP   | stop bit(s), line high
// -----------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic              load,
    input  logic [DATA_W-1:0] txdata,
    input  logic [1:0]        parity_mode,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              parity
);

    localparam int               IDX_W     = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              stop_q, stop_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;

    // par_q     : parity bit of the latched word
    // par_on_q  : latched word is sent with a parity bit
    logic              par_q;
    logic              par_on_q;

    assign accept = (state_q == S_IDLE) && load;

`ifdef UART_TX_PARITY_EN
    // Updated for every mode, so the parity output is meaningful even when
    // the frame itself carries no parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q    <= 1'b0;
            par_on_q <= 1'b0;
        end else if (accept) begin
            par_q    <= (^txdata) ^ (parity_mode == 2'b10);
            par_on_q <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        end
    end
`else
    logic unused_parity_mode;

    assign par_q              = 1'b0;
    assign par_on_q           = 1'b0;
    assign unused_parity_mode = ^parity_mode;
`endif

    // State register and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ARM;
                    shift_d = txdata;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                end
            end

            // A tick on the accepting edge was seen in IDLE and is not
            // counted; only ticks from here on move the frame forward.
            S_ARM: begin
                if (baud_tick) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end

            S_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        stop_d  = 1'b0;
                        state_d = par_on_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end

            S_STOP: begin
                if (baud_tick) begin
                    if (stop_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode, evaluated on the next state so every output is a flop.
    // tx for DATA uses the post-shift value so the new bit appears on the
    // same edge as the tick that advances it.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx     = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign parity = par_q;

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer: latches a DATA_W-bit word on `load`, computes its parity bit and serialises start, data (LSB first), optional parity and stop bits onto `tx`, one bit per `baud_tick`. Replaces the standalone 4-bit parity generator in the transmitter path. Parity is now part of a full frame, with selectable even/odd/none mode. Sits between the transmit holding logic and the baud generator.

## Interface
- `DATA_W`, 8: data bits per frame; legal 4..9.
- `STOP_BITS`, 1: stop bits per frame; legal 1 or 2.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `baud_tick` input 1: one-`clk` enable marking each bit boundary, from the baud generator.
- `load` input 1: frame request; sampled only while `busy`=0.
- `txdata` input DATA_W: word to send; sampled on the accepting edge only.
- `parity_mode` input 2: 00 none, 01 even, 10 odd, 11 none; sampled on the accepting edge.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from the cycle after acceptance through the last stop bit.
- `done` output 1: one-`clk` pulse when the final stop bit completes.
- `parity` output 1: registered parity of the latched word; valid from the cycle after acceptance until the next acceptance.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `parity`=0, state IDLE, counters 0.
- Reset mid-frame aborts immediately (asynchronous): `tx`=1, no `done` pulse.
- Acceptance: `load`=1 and state IDLE on a `clk` edge. That edge latches `txdata`, `parity_mode` and `parity`.
- Parity formula: `parity` = XOR-reduce(`txdata`) XOR (mode==10). The `parity` register is updated for every mode, including none.
- `load` while `busy`=1 is ignored with no queuing. `txdata` changes after acceptance have no effect.
- States:
  - IDLE: `tx`=1. Accept → ARM.
  - ARM: `tx`=1. Next `baud_tick` → START. A tick coinciding with the accepting edge is not counted.
  - START: `tx`=0. Next tick → DATA with bit index 0.
  - DATA: `tx`=shift[0]. On each tick, shift right and increment the index. The tick ending bit DATA_W-1 → PARITY if mode is 01/10, else → STOP.
  - PARITY: `tx`=latched parity bit. Tick → STOP.
  - STOP: `tx`=1 for STOP_BITS ticks. The last of those ticks → IDLE, `done`=1 for that one cycle, `busy`=0 in the same cycle.
- Bit index counter width: clog2(DATA_W+1). Stop counter: 1 bit.
- Back-to-back frames: `load` in the cycle `done`=1 is accepted; the next frame starts at the next tick after ARM.

## Timing
- All outputs are registered. `tx` changes only on the `clk` edge where `baud_tick`=1, or on the edge leaving IDLE.
- Acceptance → `busy`=1 and `parity` valid: 1 cycle.
- Acceptance → start bit: first `baud_tick` strictly after the accepting edge, with `tx`=0 on the following cycle.
- Frame length in ticks, after ARM: 1 + DATA_W + P + STOP_BITS, where P=1 for even/odd and 0 otherwise.
- `baud_tick` held high continuously: one bit per `clk`, which is legal.
- `baud_tick` absent: state holds indefinitely.

## Configuration
- `UART_TX_PARITY_EN` defined: parity logic, the PARITY state and the `parity_mode` decode are compiled in, as described above.
- `UART_TX_PARITY_EN` undefined: no parity hardware. `parity_mode` is ignored and `parity` is tied 0. DATA always goes → STOP, and every frame is 1 + DATA_W + STOP_BITS ticks.

## Test plan
- DATA_W=4, even, `txdata`=4'h7, `load` pulse with tick every 4 clk → `parity`=1 after one cycle; `tx` bits sequence 0,1,1,1,0,1,1 (start, data LSB first, parity, stop); `done` pulses once.
- DATA_W=4, odd, `txdata`=4'h0 → `parity`=1; frame 0,0,0,0,0,1,1. Same data with mode 00 → 0,0,0,0,0,1 (6 ticks).
- DATA_W=8, STOP_BITS=2, even, 8'hA5 → `parity`=0; `tx` high for 2 ticks after parity; `busy` falls with `done` after 12 ticks.
- `load` with `txdata`=8'h3C asserted mid-frame → ignored; the in-flight frame's bits are unchanged, and only one `done` occurs.
- `rst_n` low during DATA → `tx`=1, `busy`=0 asynchronously; after release, a new `load` of 8'h01 produces a clean frame.
- Build without `UART_TX_PARITY_EN`, even mode, 4'h7 → `parity`=0; frame 0,1,1,1,0,1 with no parity bit.
